// File: rtl/amt_repair_sequencer_if.sv
// Bundle between the Active List/RMT side and the AMT repair sequencer.
// Consolidation lookup signals exist only when REPAIR_CONSOLIDATE_EN is defined.
interface amt_repair_sequencer_if #(
  parameter int SIZE_RMT_LOG = 6,
  parameter int N_PACKETS    = 4
);
  logic                              amtRamReady_i;
  logic                              recoverReq_i;
  logic                              exceptionReq_i;
  logic                              rmtStall_i;
  logic                              repairFlag_o;
  logic [N_PACKETS*SIZE_RMT_LOG-1:0] repairAddr_o;
  logic [N_PACKETS-1:0]              repairValid_o;
  logic                              repairDone_o;
  logic                              repairDoneExc_o;
  logic                              frontendStall_o;
  logic                              busy_o;
`ifdef REPAIR_CONSOLIDATE_EN
  logic                              consolidateReq_i;
  logic [SIZE_RMT_LOG-1:0]           consolidateAddr_i;
  logic                              consolidateGrant_o;

  modport master (
    input  amtRamReady_i, recoverReq_i, exceptionReq_i, rmtStall_i,
           consolidateReq_i, consolidateAddr_i,
    output repairFlag_o, repairAddr_o, repairValid_o, repairDone_o,
           repairDoneExc_o, frontendStall_o, busy_o, consolidateGrant_o
  );
  modport slave (
    output amtRamReady_i, recoverReq_i, exceptionReq_i, rmtStall_i,
           consolidateReq_i, consolidateAddr_i,
    input  repairFlag_o, repairAddr_o, repairValid_o, repairDone_o,
           repairDoneExc_o, frontendStall_o, busy_o, consolidateGrant_o
  );
`else
  modport master (
    input  amtRamReady_i, recoverReq_i, exceptionReq_i, rmtStall_i,
    output repairFlag_o, repairAddr_o, repairValid_o, repairDone_o,
           repairDoneExc_o, frontendStall_o, busy_o
  );
  modport slave (
    output amtRamReady_i, recoverReq_i, exceptionReq_i, rmtStall_i,
    input  repairFlag_o, repairAddr_o, repairValid_o, repairDone_o,
           repairDoneExc_o, frontendStall_o, busy_o
  );
`endif
endinterface

// File: rtl/amt_repair_sequencer.sv
// Rebuilds the RMT from the AMT after mispredict/violation/exception, walking N_PACKETS segments in parallel.
// Optional read-only consolidation lookup enabled by defining REPAIR_CONSOLIDATE_EN.
module amt_repair_sequencer #(
  parameter int SIZE_RMT     = 34,
  parameter int SIZE_RMT_LOG = 6,
  parameter int N_PACKETS    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  amt_repair_sequencer_if.master bus
);
  localparam int N_CYCLES = (SIZE_RMT + N_PACKETS - 1) / N_PACKETS;
  localparam int CNT_W    = SIZE_RMT_LOG + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_CYCLES - 1);

  localparam logic [1:0] WAIT_RAM = 2'd0;
  localparam logic [1:0] IDLE     = 2'd1;
  localparam logic [1:0] REPAIR   = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]                        state_r, nextState_s;
  logic [CNT_W-1:0]                  counter_r, nextCounter_s;
  logic                              excPending_r, nextExc_s;
  logic                              req_s;
  logic                              consolidate_s;
  logic [31:0]                       fullAddr_s;
  logic [N_PACKETS*SIZE_RMT_LOG-1:0] nextAddr_s;
  logic [N_PACKETS-1:0]              nextInRange_s;
  logic                              repairFlag_r;
  logic [N_PACKETS*SIZE_RMT_LOG-1:0] repairAddr_r;
  logic [N_PACKETS-1:0]              inRange_r;
  logic                              repairDone_r;
  logic                              repairDoneExc_r;
  logic                              frontendStall_r;
  logic                              consolidateGrant_r;

  assign req_s = bus.recoverReq_i | bus.exceptionReq_i;

`ifdef REPAIR_CONSOLIDATE_EN
  logic [SIZE_RMT_LOG-1:0] consolidateAddr_s;
  assign consolidate_s          = (state_r == IDLE) && !req_s && bus.consolidateReq_i;
  assign consolidateAddr_s      = bus.consolidateAddr_i;
  assign bus.consolidateGrant_o = consolidateGrant_r;
`else
  assign consolidate_s = 1'b0;
`endif

  // Next-state, walk position and exception accumulation; restart beats DONE
  always_comb begin
    nextState_s   = state_r;
    nextCounter_s = counter_r;
    nextExc_s     = excPending_r;
    case (state_r)
      WAIT_RAM: begin
        if (bus.amtRamReady_i) nextState_s = IDLE;
        else                   nextState_s = WAIT_RAM;
      end
      IDLE: begin
        if (req_s) begin
          nextState_s   = REPAIR;
          nextCounter_s = '0;
          nextExc_s     = bus.exceptionReq_i;
        end else begin
          nextState_s = IDLE;
          nextExc_s   = 1'b0;
        end
      end
      REPAIR: begin
        if (req_s) begin
          nextCounter_s = '0;
          nextExc_s     = excPending_r | bus.exceptionReq_i;
        end else if (bus.rmtStall_i) begin
          nextCounter_s = counter_r;
        end else if (counter_r == LAST_COUNT) begin
          nextState_s = DONE;
        end else begin
          nextCounter_s = counter_r + CNT_W'(1);
        end
      end
      DONE: begin
        nextCounter_s = '0;
        if (req_s) begin
          nextState_s = REPAIR;
          nextExc_s   = bus.exceptionReq_i;
        end else begin
          nextState_s = IDLE;
          nextExc_s   = 1'b0;
        end
      end
      default: begin
        nextState_s   = WAIT_RAM;
        nextCounter_s = '0;
        nextExc_s     = 1'b0;
      end
    endcase
  end

  // Segment addresses for the next cycle; range test done before truncation
  always_comb begin
    nextAddr_s    = '0;
    nextInRange_s = '0;
    fullAddr_s    = '0;
    for (int i = 0; i < N_PACKETS; i++) begin
      fullAddr_s = 32'(i * N_CYCLES) + 32'(nextCounter_s);
      if (nextState_s == REPAIR) begin
        nextAddr_s[i*SIZE_RMT_LOG +: SIZE_RMT_LOG] = fullAddr_s[SIZE_RMT_LOG-1:0];
        nextInRange_s[i] = (fullAddr_s < 32'(SIZE_RMT));
      end else begin
        nextAddr_s[i*SIZE_RMT_LOG +: SIZE_RMT_LOG] = '0;
        nextInRange_s[i] = 1'b0;
      end
    end
`ifdef REPAIR_CONSOLIDATE_EN
    if (consolidate_s) nextAddr_s[SIZE_RMT_LOG-1:0] = consolidateAddr_s;
    else               nextAddr_s[SIZE_RMT_LOG-1:0] = nextAddr_s[SIZE_RMT_LOG-1:0];
`endif
  end

  // Controller state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= WAIT_RAM;
      counter_r    <= '0;
      excPending_r <= 1'b0;
    end else begin
      state_r      <= nextState_s;
      counter_r    <= nextCounter_s;
      excPending_r <= nextExc_s;
    end
  end

  // Output registers loaded from the next-state view
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      repairFlag_r       <= 1'b0;
      repairAddr_r       <= '0;
      inRange_r          <= '0;
      repairDone_r       <= 1'b0;
      repairDoneExc_r    <= 1'b0;
      frontendStall_r    <= 1'b1;
      consolidateGrant_r <= 1'b0;
    end else begin
      repairFlag_r       <= (nextState_s == REPAIR) | consolidate_s;
      repairAddr_r       <= nextAddr_s;
      inRange_r          <= nextInRange_s;
      repairDone_r       <= (nextState_s == DONE);
      repairDoneExc_r    <= (nextState_s == DONE) & nextExc_s;
      frontendStall_r    <= (nextState_s != IDLE);
      consolidateGrant_r <= consolidate_s;
    end
  end

  // RMT backpressure gates the write enables in the cycle it is raised
  assign bus.repairValid_o   = inRange_r & {N_PACKETS{~bus.rmtStall_i}};
  assign bus.repairFlag_o    = repairFlag_r;
  assign bus.repairAddr_o    = repairAddr_r;
  assign bus.repairDone_o    = repairDone_r;
  assign bus.repairDoneExc_o = repairDoneExc_r;
  assign bus.frontendStall_o = frontendStall_r;
  assign bus.busy_o          = repairFlag_r;

`ifndef REPAIR_CONSOLIDATE_EN
  logic unusedGrant_s;
  assign unusedGrant_s = consolidateGrant_r;
`endif
endmodule

// File: tb/tb_amt_repair_sequencer.sv
// Randomized bench for amt_repair_sequencer against a cycle-level behavioural model and write-once scoreboard.
// Consolidation checks are compiled in when REPAIR_CONSOLIDATE_EN is defined.
module tb_amt_repair_sequencer;
  localparam int SIZE_RMT     = 34;
  localparam int SIZE_RMT_LOG = 6;
  localparam int N_PACKETS    = 4;
  localparam int N_CYCLES     = 9;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  amt_repair_sequencer_if #(.SIZE_RMT_LOG(SIZE_RMT_LOG), .N_PACKETS(N_PACKETS)) bus ();

  amt_repair_sequencer #(
    .SIZE_RMT(SIZE_RMT), .SIZE_RMT_LOG(SIZE_RMT_LOG), .N_PACKETS(N_PACKETS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: table up, walk position (-1 = not walking), DONE pulse, exception memory
  bit mRamUp;
  int mPos;
  bit mDone, mDoneExc, mExcAcc;
  int wrCnt[SIZE_RMT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mRamUp = 1'b0; mPos = -1; mDone = 1'b0; mDoneExc = 1'b0; mExcAcc = 1'b0;
    for (int a = 0; a < SIZE_RMT; a++) wrCnt[a] = 0;
  endtask

  task automatic checkOutputs();
    logic [N_PACKETS*SIZE_RMT_LOG-1:0] eAddr;
    logic [N_PACKETS-1:0]              eValid;
    int a, oa;
    eAddr  = '0;
    eValid = '0;
    if (mPos >= 0) begin
      for (int i = 0; i < N_PACKETS; i++) begin
        a = i * N_CYCLES + mPos;
        eAddr[i*SIZE_RMT_LOG +: SIZE_RMT_LOG] = a[SIZE_RMT_LOG-1:0];
        eValid[i] = (a < SIZE_RMT) && !bus.rmtStall_i;
      end
    end
    chk("repairFlag", 32'(bus.repairFlag_o), 32'(mPos >= 0));
    chk("busy", 32'(bus.busy_o), 32'(mPos >= 0));
    chk("repairAddr", 32'(bus.repairAddr_o), 32'(eAddr));
    chk("repairValid", 32'(bus.repairValid_o), 32'(eValid));
    chk("repairDone", 32'(bus.repairDone_o), 32'(mDone));
    chk("repairDoneExc", 32'(bus.repairDoneExc_o), 32'(mDone & mDoneExc));
    chk("frontendStall", 32'(bus.frontendStall_o), 32'(!mRamUp || mPos >= 0 || mDone));
    for (int i = 0; i < N_PACKETS; i++) begin
      if (bus.repairValid_o[i]) begin
        oa = 32'(bus.repairAddr_o[i*SIZE_RMT_LOG +: SIZE_RMT_LOG]);
        chk("validAddrInRange", 32'(oa < SIZE_RMT), 32'd1);
        if (oa < SIZE_RMT) wrCnt[oa]++;
      end
    end
  endtask

  task automatic modelStep(input bit rec, input bit exc, input bit stall, input bit rdy);
    bit nd;
    nd = 1'b0;
    if (!mRamUp) begin
      if (rdy) mRamUp = 1'b1;
    end else if (rec || exc) begin
      mExcAcc = ((mPos >= 0) ? mExcAcc : 1'b0) | exc;
      mPos    = 0;
      for (int a = 0; a < SIZE_RMT; a++) wrCnt[a] = 0;
    end else if (mPos >= 0 && !stall) begin
      if (mPos == N_CYCLES - 1) begin
        for (int a = 0; a < SIZE_RMT; a++) chk($sformatf("writeOnce[%0d]", a), 32'(wrCnt[a]), 32'd1);
        nd       = 1'b1;
        mDoneExc = mExcAcc;
        mPos     = -1;
      end else begin
        mPos++;
      end
    end
    mDone = nd;
  endtask

  // One clock: drive at negedge, check, let the edge happen, advance the model
  task automatic cycle(input bit rec, input bit exc, input bit stall, input bit rdy);
    bus.recoverReq_i   = rec;
    bus.exceptionReq_i = exc;
    bus.rmtStall_i     = stall;
    bus.amtRamReady_i  = rdy;
    #1;
    checkOutputs();
    @(posedge clk);
    modelStep(rec, exc, stall, rdy);
    @(negedge clk);
  endtask

  task automatic applyReset();
    bus.recoverReq_i   = 1'b0;
    bus.exceptionReq_i = 1'b0;
    bus.rmtStall_i     = 1'b0;
    bus.amtRamReady_i  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rstFlag", 32'(bus.repairFlag_o), 32'd0);
    chk("rstValid", 32'(bus.repairValid_o), 32'd0);
    chk("rstAddr", 32'(bus.repairAddr_o), 32'd0);
    chk("rstDone", 32'(bus.repairDone_o), 32'd0);
    chk("rstDoneExc", 32'(bus.repairDoneExc_o), 32'd0);
    chk("rstStall", 32'(bus.frontendStall_o), 32'd1);
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.recoverReq_i   = 1'b0;
    bus.exceptionReq_i = 1'b0;
    bus.rmtStall_i     = 1'b0;
    bus.amtRamReady_i  = 1'b0;
`ifdef REPAIR_CONSOLIDATE_EN
    bus.consolidateReq_i  = 1'b0;
    bus.consolidateAddr_i = '0;
`endif
    modelReset();
    @(negedge clk);
    applyReset();

    // Table init: a request while waiting is dropped, ready arrives at cycle 5
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Clean recovery pass
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (11) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure for three cycles at counter 4
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (7) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Exception joins at counter 6 and restarts the walk
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (11) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Request taken in the DONE cycle, then reset at counter 3
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (9) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    applyReset();
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef REPAIR_CONSOLIDATE_EN
    // Read-only lookup from IDLE, then a recovery that outranks it
    bus.consolidateReq_i  = 1'b1;
    bus.consolidateAddr_i = 6'd17;
    @(posedge clk);
    @(negedge clk);
    bus.consolidateReq_i = 1'b0;
    #1;
    chk("consFlag", 32'(bus.repairFlag_o), 32'd1);
    chk("consAddr0", 32'(bus.repairAddr_o[SIZE_RMT_LOG-1:0]), 32'd17);
    chk("consValid", 32'(bus.repairValid_o), 32'd0);
    chk("consGrant", 32'(bus.consolidateGrant_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.consolidateReq_i = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    bus.consolidateReq_i = 1'b0;
    #1;
    chk("consGrantLoses", 32'(bus.consolidateGrant_o), 32'd0);
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic with occasional resets and slow table init
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        applyReset();
      end else begin
        cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 49) == 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
